// File: rtl/piso_tx.sv
// piso_tx: parallel-in, serial-out word transmitter.
//
// Accepts a WIDTH-bit word through a load_valid/load_ready handshake and
// shifts it out LSB-first, one bit per clock, framed by sout_valid. A
// registered done pulse follows the last frame bit.
//
// Optional feature macro: PISO_TX_PARITY_EN
//   defined   -> an even-parity bit (XOR of the data bits) follows the data,
//                so each frame carries WIDTH+1 qualified bits.
//   undefined -> each frame carries exactly WIDTH qualified bits.
//
// All outputs are decoded from registered state only, so there is no
// combinational path from any input to any output.

module piso_tx #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] din,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic             done
);

    // Counter only has to reach WIDTH-1, so $clog2(WIDTH) bits suffice.
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

`ifdef PISO_TX_PARITY_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;
`else
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;
`endif

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic             handshake;
    logic             done_next;
`ifdef PISO_TX_PARITY_EN
    logic             parity_q;
`endif

    // State register; reset aborts any frame in progress and returns to IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and output decode; every output depends on registered state only.
    always_comb begin
        state_next = state;
        handshake  = 1'b0;
        done_next  = 1'b0;
        load_ready = 1'b0;
        sout       = 1'b0;
        sout_valid = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    handshake  = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                sout       = shreg[0];
                sout_valid = 1'b1;
                busy       = 1'b1;
                if (cnt == LAST_BIT) begin
`ifdef PISO_TX_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = IDLE;
                    done_next  = 1'b1;
`endif
                end
            end
`ifdef PISO_TX_PARITY_EN
            PARITY: begin
                sout       = parity_q;
                sout_valid = 1'b1;
                busy       = 1'b1;
                state_next = IDLE;
                done_next  = 1'b1;
            end
`endif
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Shift register and bit counter: load on handshake, shift right with zero fill while shifting.
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (handshake) begin
            shreg <= din;
            cnt   <= '0;
        end else if (state == SHIFT) begin
            shreg <= {1'b0, shreg[WIDTH-1:1]};
            cnt   <= cnt + 1'b1;
        end
    end

`ifdef PISO_TX_PARITY_EN
    // Even parity of the captured word, computed once at load time.
    always_ff @(posedge clk) begin
        if (reset) begin
            parity_q <= 1'b0;
        end else if (handshake) begin
            parity_q <= ^din;
        end
    end
`endif

    // Done pulse: set on the edge leaving the last frame-bit state, cleared on the next edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            done <= 1'b0;
        end else begin
            done <= done_next;
        end
    end

endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: self-checking bench for piso_tx (WIDTH=4).
// Expected serial frames come from a word-level model: data bits LSB-first,
// then the XOR of the word when PISO_TX_PARITY_EN is defined.

module tb_piso_tx;

    localparam int W = 4;
`ifdef PISO_TX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic         clk;
    logic         reset;
    logic         load_valid;
    logic         load_ready;
    logic [W-1:0] din;
    logic         sout;
    logic         sout_valid;
    logic         busy;
    logic         done;
    logic [W-1:0] rx;

    int vectors;
    int miscompares;

    piso_tx #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .din        (din),
        .sout       (sout),
        .sout_valid (sout_valid),
        .busy       (busy),
        .done       (done)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Loopback receiver: right shift with MSB insert, only on qualified bits.
    always @(posedge clk) begin
        if (reset) begin
            rx <= '0;
        end else if (sout_valid) begin
            rx <= {sout, rx[W-1:1]};
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic lv, input logic [W-1:0] d, input logic rst);
        load_valid = lv;
        din        = d;
        reset      = rst;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkIdle(input string tag, input logic expDone);
        checkOutput({tag, "_sout"}, 32'(sout), 32'd0);
        checkOutput({tag, "_sout_valid"}, 32'(sout_valid), 32'd0);
        checkOutput({tag, "_load_ready"}, 32'(load_ready), 32'd1);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_done"}, 32'(done), 32'(expDone));
    endtask

    // Send one word from an idle cycle and check the whole frame against the model.
    // Returns standing in the done cycle. With hold set, load_valid stays high and
    // din is scrambled during the frame, which must not disturb it.
    task automatic sendWord(input logic [W-1:0] word, input bit hold);
        bit           frame[$];
        logic [W-1:0] expRx;
        for (int i = 0; i < W; i++) frame.push_back(word[i]);
        if (PAR) frame.push_back(^word);
        expRx = PAR ? {^word, word[W-1:1]} : word;

        checkOutput("ready_before_load", 32'(load_ready), 32'd1);
        applyStimulus(1'b1, word, 1'b0);
        tick();
        if (!hold) load_valid = 1'b0;
        foreach (frame[i]) begin
            checkOutput($sformatf("frame_bit%0d", i), 32'(sout), 32'(frame[i]));
            checkOutput("frame_sout_valid", 32'(sout_valid), 32'd1);
            checkOutput("frame_load_ready", 32'(load_ready), 32'd0);
            checkOutput("frame_busy", 32'(busy), 32'd1);
            checkOutput("frame_done", 32'(done), 32'd0);
            if (hold) din = W'($urandom);
            tick();
        end
        checkIdle("end_of_frame", 1'b1);
        checkOutput("loopback_rx", 32'(rx), 32'(expRx));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        applyStimulus(1'b0, '0, 1'b1);
        tick();
        tick();

        $display("[TB] reset state");
        applyStimulus(1'b0, '0, 1'b0);
        checkIdle("reset", 1'b0);
        tick();
        checkIdle("post_reset", 1'b0);

        $display("[TB] basic frame 1011 and loopback 0110");
        sendWord(4'b1011, 1'b0);
        tick();
        checkIdle("done_cleared", 1'b0);
        sendWord(4'b0110, 1'b0);
        tick();

        $display("[TB] held valid, back-to-back A then 5");
        sendWord(4'hA, 1'b1);
        sendWord(4'h5, 1'b0);
        tick();
        checkIdle("after_held", 1'b0);

        $display("[TB] reset mid-frame");
        applyStimulus(1'b1, 4'b1111, 1'b0);
        tick();
        load_valid = 1'b0;
        checkOutput("abort_bit0", 32'(sout), 32'd1);
        tick();
        checkOutput("abort_bit1", 32'(sout), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkIdle("abort", 1'b0);
        for (int i = 0; i < W + 2; i++) begin
            tick();
            checkIdle("abort_quiet", 1'b0);
        end

        $display("[TB] reset and handshake on the same edge");
        applyStimulus(1'b1, 4'b1001, 1'b1);
        tick();
        applyStimulus(1'b0, '0, 1'b0);
        checkIdle("rst_vs_hs", 1'b0);
        for (int i = 0; i < W + 2; i++) begin
            tick();
            checkIdle("rst_vs_hs_quiet", 1'b0);
        end

        $display("[TB] randomized words");
        for (int n = 0; n < 24; n++) begin
            logic [W-1:0] w;
            int           gap;
            bit           hold;
            w    = W'($urandom);
            gap  = $urandom_range(0, 2);
            hold = bit'($urandom_range(0, 1));
            for (int g = 0; g < gap; g++) begin
                applyStimulus(1'b0, W'($urandom), 1'b0);
                tick();
                checkIdle("rand_gap", 1'b0);
            end
            sendWord(w, hold);
        end
        load_valid = 1'b0;
        tick();
        checkIdle("final", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/piso_tx.md
# piso_tx

Parallel-in, serial-out word transmitter that feeds the single-bit serial lane consumed by the team's shift-register receivers. It accepts a WIDTH-bit word through a valid/ready handshake and shifts it out LSB-first, one bit per clock. A `sout_valid` qualifier frames each word, an optional parity bit can follow the data, and a `done` pulse marks completion. LSB-first order means a right-shifting receiver that inserts at its MSB holds the original word after WIDTH qualified shifts.

## Interface
- `WIDTH`, default 4: data bits per word; legal range 2..32.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high; sampled on the rising edge of `clk`.
- `load_valid` input 1: producer has a word on `din`.
- `load_ready` output 1: block can accept a word; high only in IDLE.
- `din` input WIDTH: parallel word; sampled only on a handshake edge.
- `sout` output 1: serial data, LSB first.
- `sout_valid` output 1: high in every cycle `sout` carries a frame bit (data or parity).
- `busy` output 1: high while in SHIFT or PARITY.
- `done` output 1: one-cycle pulse in the cycle after the last frame bit.

## Operation
- State register: IDLE, SHIFT, PARITY (PARITY exists only with the macro). Also a WIDTH-bit shift register `shreg`, a bit counter of $clog2(WIDTH) bits, a parity flop, and a `done` flop.
- Reset values: state IDLE, `shreg` 0, counter 0, `done` 0. After reset: `load_ready`=1, `sout`=0, `sout_valid`=0, `busy`=0.
- IDLE: `load_ready`=1. A handshake occurs on an edge where `load_valid`=1 and `load_ready`=1. On a handshake edge:
  - `din` is loaded into `shreg`.
  - The counter is cleared.
  - The parity flop is loaded with `^din`.
  - The state moves to SHIFT.
- SHIFT: `sout`=`shreg[0]`, `sout_valid`=1, `load_ready`=0. On each edge:
  - `shreg` shifts right and 0 enters the MSB.
  - The counter increments.
- Leaving SHIFT: on the edge where counter = WIDTH-1, the state moves to PARITY (macro defined) or IDLE (macro undefined).
- PARITY: `sout`=parity flop, `sout_valid`=1. The state returns to IDLE on the next edge.
- `done`: registered. It is set on the edge that leaves the last frame-bit state and is cleared on the following edge.
- Outside SHIFT/PARITY: `sout`=0 and `sout_valid`=0.
- No combinational path from any input to any output. All outputs are decoded from registered state only.
- `load_valid` and `din` are ignored outside IDLE. Holding `load_valid` high during a frame has no effect, and no second word is captured until IDLE.
- Reset mid-frame aborts immediately:
  - The next cycle is IDLE with `sout`=0, `sout_valid`=0.
  - No `done` pulse is generated for the aborted word.
  - If reset and a handshake occur on the same edge, reset wins and the word is dropped.

## Timing
- Handshake on edge k. Data bit i (i=0..WIDTH-1) is on `sout` during the cycle after edge k+i.
- Parity bit, when compiled in, is on `sout` during the cycle after edge k+WIDTH.
- `done`=1 and `load_ready`=1 in the same cycle:
  - the cycle after edge k+WIDTH without parity;
  - the cycle after edge k+WIDTH+1 with parity.
- Minimum handshake-to-handshake spacing:
  - WIDTH+1 cycles without parity;
  - WIDTH+2 cycles with parity.
- There is always exactly one idle cycle between frames, so `sout_valid` drops for at least one cycle between words.

## Configuration
- `PISO_TX_PARITY_EN` defined:
  - PARITY state is present.
  - Each frame is WIDTH+1 qualified bits; the final bit is even parity (XOR of the data bits).
- Undefined:
  - No PARITY state and no parity flop.
  - Each frame is exactly WIDTH qualified bits.

## Test plan
- Basic frame: WIDTH=4, no macro, `din`=4'b1011 with `load_valid` pulsed -> `sout`=1,1,0,1 in the four cycles after the handshake with `sout_valid`=1; `done`=1 on the fifth; `load_ready` 0 in cycles 1–4.
- Parity frame: `PISO_TX_PARITY_EN`, `din`=4'b1011 -> data bits 1,1,0,1 then parity 1; `din`=4'b0110 -> parity 0; `done` one cycle after the parity bit.
- Loopback: `sout` feeds a right-shifting 4-bit receiver (MSB insert, shift enabled only when `sout_valid`=1), `din`=4'b0110 -> receiver holds 4'b0110 when `done`=1.
- Held valid: `load_valid` tied high, words 4'hA then 4'h5 -> second handshake exactly 5 cycles after the first (no parity); `sout` sequence 0,1,0,1,(idle 0),1,0,1,0.
- Reset mid-frame: assert `reset` after the second data bit of 4'b1111 -> next cycle `sout`=0, `sout_valid`=0, `load_ready`=1, `busy`=0; no `done` pulse.
- Reset vs handshake: `reset` and a handshake on the same edge -> state IDLE, no bits emitted, word dropped.
